stream_reduce_unit: RTL and testbench
=====================================

// Module: stream_reduce_unit
// PURPOSE
//  Multi-channel streaming unary-reduction engine: folds AND/OR/XOR/XNOR over every masked bit
//  of a multi-beat packet per channel and emits one result per packet.
//  The 1-bit result is zero- or sign-extended to OUT_W.
//  Sits between a valid/ready beat source and a result consumer.
//  Successor to the combinational reduction/extension datapath: adds packets, channels, modes, backpressure.
// PARAMETERS
//  DATA_W  32  beat width in bits (>=1)
//  NCHAN   4   independent channels (>=1); CH_W = max(1,$clog2(NCHAN))
//  OUT_W   8   result width (>=1); the 1-bit reduction is extended to this width
//  CNT_W   6   beat-counter width; the counter saturates at 2^CNT_W-1
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       beat valid
//  in_ready   out  1       beat accepted when in_valid & in_ready
//  in_chan    in   CH_W    channel id of beat; values >= NCHAN are accepted and dropped
//  in_data    in   DATA_W  beat payload
//  in_mask    in   DATA_W  1 = bit participates; 0 = bit replaced by op identity
//  in_last    in   1       final beat of packet on in_chan
//  in_op      in   2       red_op_e; sampled on first beat of packet only
//  in_signed  in   1       1 = sign-extend result; sampled on first beat only
//  out_valid  out  1       result valid
//  out_ready  in   1       result consumed when out_valid & out_ready
//  out_chan   out  CH_W    channel of result
//  out_data   out  OUT_W   extended reduction result
//  out_beats  out  CNT_W   beats in packet (saturating)
//  out_sat    out  1       beat counter saturated during packet
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_chan=0, out_data=0, out_beats=0, out_sat=0.
//   All channel lanes go idle with acc/cnt/sat cleared. in_ready=1 once rst_n is high.
//   A packet in progress when reset asserts is discarded; no partial result is emitted.
//  in_ready = !out_valid | out_ready. The same value applies to last and non-last beats.
//  Per-lane state: active, op, sgn, acc (1b), cnt (CNT_W), sat.
//  Beat-level reduction r = reduce_op(in_data | ~in_mask) for AND; reduce_op(in_data & in_mask) for OR/XOR/XNOR(xor core).
//  First beat (lane idle):
//   - latch op and sgn
//   - acc = r
//   - cnt = 1
//   - set active unless in_last
//  Later beats:
//   - acc = acc op r (XNOR accumulates as XOR)
//   - cnt = cnt+1, saturating; sat set on saturation
//   - in_op and in_signed are ignored
//  Final bit f = (op==XNOR) ? ~acc_next : acc_next.
//   out_data = sgn ? {OUT_W{f}} : {{OUT_W-1{1'b0}},f}.
//  Accepted last beat: result registered next cycle (latency 1). Lane returns to idle with cleared state.
//   A single-beat packet uses first-beat state directly.
//  Output register holds all fields stable while out_valid & !out_ready.
//  Output handoff in one cycle: out fire plus accepted last beat loads the new result; out_valid stays 1.
//  Channels are independent; interleaving beats of different channels is legal. Other lanes are untouched by a beat.
//  All-zero mask: AND/XNOR give f=1; OR/XOR give f=0.
//  Dropped beats (in_chan>=NCHAN) still follow the in_ready handshake.
//  in_data/in_mask contents with in_valid=0 are don't-care.
// STRUCTURE
//  Package sv_reduce_pkg:
//   - typedef enum logic [1:0] red_op_e {RED_AND=0, RED_OR=1, RED_XOR=2, RED_XNOR=3}
//   - function red_identity(red_op_e)
//   - function extend1(bit f, bit sgn, int w)
//  Sub-module reduce_lane: one per channel via generate.
//   Holds active/op/sgn/acc/cnt/sat and computes next state and f.
//   Top level does channel decode, handshake and the output register.
// TESTING
//  1. XOR, ch0, 1 beat, data=32'h7, mask=all1, signed=0 -> out_data=8'h01, out_beats=1, out_chan=0.
//  2. Same as 1 with signed=1 -> out_data=8'hFF. With data=32'h3 -> out_data=8'h00.
//  3. AND, mask=0, data=0 -> out_data=8'h01.
//     OR, 2 beats data=0 then 32'h8000_0000 -> 8'h01, beats=2.
//  4. Interleave ch1 XNOR (beats 32'h1, 32'h1) with ch2 OR (32'h0 last):
//     ch2 result 8'h00 first; ch1 result 8'h01, beats=2.
//     Op change on ch1's 2nd beat is ignored.
//  5. Hold out_ready=0 with a result pending -> in_ready=0 and out fields stable.
//     Release while a last beat is waiting -> next result appears the following cycle, no bubble.
//  6. Saturation and reset:
//     - CNT_W=2, 5-beat packet -> out_beats=3, out_sat=1.
//     - rst_n pulse mid-packet -> no output; next packet starts fresh with beats=1.

Source files
------------

// File: rtl/sv_reduce_pkg.sv
// Shared types and helpers for the streaming unary-reduction unit.
package sv_reduce_pkg;

  typedef enum logic [1:0] {
    RED_AND  = 2'd0,
    RED_OR   = 2'd1,
    RED_XOR  = 2'd2,
    RED_XNOR = 2'd3
  } red_op_e;

  localparam int MAX_OUT_W = 64;

  // Value a masked-off bit takes so it cannot disturb the fold.
  function automatic logic red_identity(red_op_e op);
    return (op == RED_AND);
  endfunction

  function automatic logic [MAX_OUT_W-1:0] extend1(bit f, bit sgn, int w);
    logic [MAX_OUT_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_OUT_W; i++)
      if (i < w) v[i] = (i == 0) ? f : (sgn & f);
    return v;
  endfunction

endpackage

// File: rtl/reduce_lane.sv
// Per-channel fold state: latches op/sign on the first beat and folds each beat's reduction.
module reduce_lane
  import sv_reduce_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat,
  input  logic              last,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] mask,
  input  red_op_e           new_op,
  input  logic              new_sgn,
  output logic              res_f,
  output logic              res_sgn,
  output logic [CNT_W-1:0]  res_cnt,
  output logic              res_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              active, acc, sat, sgn;
  red_op_e           op, op_eff;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] eff;
  logic              r, acc_nxt;

  always_comb begin
    op_eff  = active ? op : new_op;
    res_sgn = active ? sgn : new_sgn;
    eff     = red_identity(op_eff) ? (data | ~mask) : (data & mask);
    r       = 1'b0;
    case (op_eff)
      RED_AND: r = &eff;
      RED_OR:  r = |eff;
      default: r = ^eff;
    endcase
    acc_nxt = r;
    // XNOR folds as XOR; the inversion is applied once to the final bit.
    if (active) begin
      case (op)
        RED_AND: acc_nxt = acc & r;
        RED_OR:  acc_nxt = acc | r;
        default: acc_nxt = acc ^ r;
      endcase
    end
    res_f   = (op_eff == RED_XNOR) ? ~acc_nxt : acc_nxt;
    res_cnt = !active ? CNT_W'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
    res_sat = active & (sat | (cnt == CNT_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      op     <= RED_AND;
      sgn    <= 1'b0;
      acc    <= 1'b0;
      cnt    <= '0;
      sat    <= 1'b0;
    end else if (beat) begin
      if (last) begin
        active <= 1'b0;
        op     <= RED_AND;
        sgn    <= 1'b0;
        acc    <= 1'b0;
        cnt    <= '0;
        sat    <= 1'b0;
      end else begin
        active <= 1'b1;
        op     <= op_eff;
        sgn    <= res_sgn;
        acc    <= acc_nxt;
        cnt    <= res_cnt;
        sat    <= res_sat;
      end
    end
  end

endmodule

// File: rtl/stream_reduce_unit.sv
// Multi-channel streaming reduction: decodes beats to lanes and registers one result per packet.
module stream_reduce_unit
  import sv_reduce_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NCHAN  = 4,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 6,
  localparam int CH_W  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_chan,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_mask,
  input  logic              in_last,
  input  red_op_e           in_op,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_chan,
  output logic [OUT_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_beats,
  output logic              out_sat
);

  logic                        fire, res_load;
  logic [NCHAN-1:0]            lane_beat, lane_f, lane_sgn, lane_sat;
  logic [NCHAN-1:0][CNT_W-1:0] lane_cnt;
  logic                        sel_f, sel_sgn, sel_sat;
  logic [CNT_W-1:0]            sel_cnt;

  assign in_ready = !out_valid | out_ready;
  assign fire     = in_valid & in_ready;

  for (genvar g = 0; g < NCHAN; g++) begin : g_lane
    // Out-of-range channel ids match no lane, so those beats vanish after the handshake.
    assign lane_beat[g] = fire & (in_chan == CH_W'(g));

    reduce_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .beat    (lane_beat[g]),
      .last    (in_last),
      .data    (in_data),
      .mask    (in_mask),
      .new_op  (in_op),
      .new_sgn (in_signed),
      .res_f   (lane_f[g]),
      .res_sgn (lane_sgn[g]),
      .res_cnt (lane_cnt[g]),
      .res_sat (lane_sat[g])
    );
  end

  always_comb begin
    sel_f   = 1'b0;
    sel_sgn = 1'b0;
    sel_cnt = '0;
    sel_sat = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (in_chan == CH_W'(i)) begin
        sel_f   = lane_f[i];
        sel_sgn = lane_sgn[i];
        sel_cnt = lane_cnt[i];
        sel_sat = lane_sat[i];
      end
    end
  end

  assign res_load = (|lane_beat) & in_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
    end else if (res_load) begin
      out_valid <= 1'b1;
      out_chan  <= in_chan;
      out_data  <= OUT_W'(extend1(sel_f, sel_sgn, OUT_W));
      out_beats <= sel_cnt;
      out_sat   <= sel_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_reduce_unit.sv
// Scoreboard bench: packet-level reference model feeds an expected queue drained by a monitor.
module tb_stream_reduce_unit;
  import sv_reduce_pkg::*;

  localparam int DATA_W = 32;
  localparam int NCHAN  = 3;
  localparam int OUT_W  = 8;
  localparam int CNT_W  = 2;
  localparam int CH_W   = 2;
  localparam int CMAX   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CH_W-1:0]   in_chan = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0] in_mask = '0;
  logic              in_last = 1'b0;
  red_op_e           in_op = RED_AND;
  logic              in_signed = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CH_W-1:0]   out_chan;
  logic [OUT_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_beats;
  logic              out_sat;

  stream_reduce_unit #(.DATA_W(DATA_W), .NCHAN(NCHAN), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan),
    .in_data(in_data), .in_mask(in_mask), .in_last(in_last), .in_op(in_op),
    .in_signed(in_signed), .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_data(out_data), .out_beats(out_beats), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;  // 0 random, 1 always, 2 never

  typedef struct {
    logic [CH_W-1:0]  chan;
    logic [OUT_W-1:0] data;
    logic [CNT_W-1:0] beats;
    logic             sat;
  } exp_t;
  exp_t sb[$];

  // Packet-level model: count ones / zeros over all participating bits.
  bit      m_act [4];
  red_op_e m_op  [4];
  bit      m_sgn [4];
  int      m_n   [4];
  int      m_ones[4];
  bit      m_zero[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_accept(input int c, input logic [31:0] d, input logic [31:0] m,
                                       input bit last, input red_op_e op, input bit sg);
    bit f;
    exp_t e;
    if (c >= NCHAN) return;
    if (!m_act[c]) begin
      m_op[c] = op; m_sgn[c] = sg; m_n[c] = 0; m_ones[c] = 0; m_zero[c] = 0;
    end
    m_n[c]++;
    m_ones[c] += $countones(d & m);
    if (((~d) & m) != 0) m_zero[c] = 1;
    if (!last) begin
      m_act[c] = 1;
      return;
    end
    case (m_op[c])
      RED_AND: f = !m_zero[c];
      RED_OR:  f = (m_ones[c] > 0);
      RED_XOR: f = (m_ones[c] % 2) == 1;
      default: f = (m_ones[c] % 2) == 0;
    endcase
    e.chan  = CH_W'(c);
    e.data  = m_sgn[c] ? (f ? 8'hFF : 8'h00) : {7'b0, f};
    e.beats = CNT_W'((m_n[c] > CMAX) ? CMAX : m_n[c]);
    e.sat   = (m_n[c] > CMAX);
    sb.push_back(e);
    m_act[c] = 0;
  endfunction

  task automatic send(input int c, input logic [31:0] d, input logic [31:0] m,
                      input bit last, input red_op_e op, input bit sg);
    int  waitc = 0;
    bit  done  = 0;
    in_valid = 1; in_chan = c[CH_W-1:0]; in_data = d; in_mask = m;
    in_last = last; in_op = op; in_signed = sg;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(c, d, m, last, op, sg);
        done = 1;
      end else if (++waitc > 500) begin
        checks++; errors++;
        $display("FAIL send_timeout: chan %0d never accepted", c);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    in_data = $urandom; in_mask = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    ready_mode = 1;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial forever begin
    @(posedge clk); #2;
    case (ready_mode)
      0: out_ready = ($urandom_range(0, 3) != 0);
      1: out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops on every output handshake and checks hold stability under backpressure.
  initial begin
    exp_t e;
    bit hold = 0;
    exp_t h;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        if (hold) begin
          checks++;
          if (!out_valid || out_chan !== h.chan || out_data !== h.data ||
              out_beats !== h.beats || out_sat !== h.sat) begin
            errors++;
            $display("FAIL hold_stable: got v%0b ch%0d d%h b%0d s%0b expected ch%0d d%h b%0d s%0b",
                     out_valid, out_chan, out_data, out_beats, out_sat, h.chan, h.data, h.beats, h.sat);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: ch%0d d%h with nothing expected", out_chan, out_data);
          end else begin
            e = sb.pop_front();
            if (out_chan !== e.chan || out_data !== e.data || out_beats !== e.beats || out_sat !== e.sat) begin
              errors++;
              $display("FAIL result: got ch%0d d%h b%0d s%0b expected ch%0d d%h b%0d s%0b",
                       out_chan, out_data, out_beats, out_sat, e.chan, e.data, e.beats, e.sat);
            end
          end
        end
        hold = out_valid && !out_ready;
        h.chan = out_chan; h.data = out_data; h.beats = out_beats; h.sat = out_sat;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ones;
    ones = '1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_chan",  out_chan, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_beats", out_beats, 0);
    chk("rst_out_sat",   out_sat, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Single-beat, signedness, identities, two-beat OR
    send(0, 32'h7, ones, 1, RED_XOR, 0);
    send(0, 32'h7, ones, 1, RED_XOR, 1);
    send(0, 32'h3, ones, 1, RED_XOR, 1);
    send(0, 32'h0, 32'h0, 1, RED_AND, 0);
    send(1, 32'h0, 32'h0, 1, RED_XNOR, 1);
    send(2, $urandom, 32'h0, 1, RED_OR, 1);
    send(2, 32'h0, ones, 0, RED_OR, 0);
    send(2, 32'h8000_0000, ones, 1, RED_AND, 0);

    // Interleave; the op on ch1's second beat must be ignored; ch3 beats are dropped
    send(1, 32'h1, ones, 0, RED_XNOR, 0);
    send(2, 32'h0, ones, 1, RED_OR, 0);
    send(3, ones, ones, 1, RED_AND, 1);
    send(1, 32'h1, ones, 1, RED_AND, 1);

    // Saturation: five beats on a 2-bit counter, and exactly three beats
    for (int i = 0; i < 5; i++) send(1, $urandom, $urandom, i == 4, RED_XOR, 0);
    for (int i = 0; i < 3; i++) send(0, ones, ones, i == 2, RED_AND, 1);
    drain();

    // Backpressure then one-cycle handoff
    ready_mode = 2;
    send(0, 32'h1, ones, 1, RED_OR, 0);
    fork
      send(2, 32'h1, ones, 1, RED_OR, 1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clk); #1;
        ready_mode = 1;
      end
    join
    @(negedge clk);
    chk("handoff_valid", out_valid, 1);
    chk("handoff_chan", out_chan, 2);
    drain();

    // Randomized interleaved traffic with random backpressure
    ready_mode = 0;
    for (int i = 0; i < 400; i++) begin
      int c;
      logic [31:0] d, m;
      c = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, NCHAN - 1);
      d = ($urandom_range(0, 3) == 0) ? ones : $urandom;
      case ($urandom_range(0, 5))
        0: m = '0;
        1: m = ones;
        2: m = 32'h1 << $urandom_range(0, 31);
        default: m = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 0;
        @(posedge clk); #1;
      end
      send(c, d, m, $urandom_range(0, 2) == 0, red_op_e'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end
    drain();

    // Reset mid-packet: partial packets vanish and lanes restart
    send(0, 32'h1, ones, 0, RED_XOR, 0);
    send(1, ones, ones, 0, RED_AND, 0);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    for (int c = 0; c < 4; c++) m_act[c] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    send(0, 32'h1, ones, 1, RED_XOR, 0);
    send(1, 32'h0, ones, 1, RED_OR, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
